// File: rtl/step_sequencer_pkg.sv
// Shared definitions for the step/dir/enable motion sequencer.
// Holds the state encoding, default widths and direction constants.
package step_sequencer_pkg;

    localparam int CT_W_DEF  = 32;
    localparam int PER_W_DEF = 32;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } state_t;

endpackage

// File: rtl/step_sequencer_timer.sv
// step_timer: loadable down-counter with a zero flag.
// One instance times the setup, step-high and step-low intervals in turn.
module step_timer #(
    parameter int PER_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [PER_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [PER_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - PER_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/step_sequencer.sv
// Motion sequencer driving step/dir/enable of the H-bridge phase driver.
// Optional idle auto-disable is built when STEP_SEQ_IDLE_TIMEOUT_EN is defined.
//
// state    | meaning
// ST_IDLE  | waiting for a command, cmd_ready may be high
// ST_SETUP | dir changed or driver just woke, hold dir before first edge
// ST_HIGH  | step high for PULSE_W cycles
// ST_LOW   | step low for the rest of the effective period
module step_sequencer
    import step_sequencer_pkg::*;
#(
    parameter int CT_W      = CT_W_DEF,
    parameter int PER_W     = PER_W_DEF,
    parameter int PULSE_W   = 16,
    parameter int DIR_SETUP = 8
`ifdef STEP_SEQ_IDLE_TIMEOUT_EN
    , parameter int IDLE_TIMEOUT = 1000000
`endif
) (
    input  logic             CLK,
    input  logic             resetn,
    input  logic             enable_in,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CT_W-1:0]  cmd_steps,
    input  logic             cmd_dir,
    input  logic [PER_W-1:0] cmd_period,
    input  logic             halt,
    output logic             step,
    output logic             dir,
    output logic             motor_en,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CT_W-1:0]  position
);

    localparam logic [PER_W:0]   TWO_PW     = (PER_W+1)'(2 * PULSE_W);
    localparam logic [PER_W-1:0] HIGH_LOAD  = PER_W'(PULSE_W - 1);
    localparam logic [PER_W-1:0] SETUP_LOAD = PER_W'(DIR_SETUP - 1);

    state_t           r_state;
    logic             r_step;
    logic             r_dir;
    logic             r_motor_en;
    logic             r_done;
    logic             r_aborted;
    logic [CT_W-1:0]  r_position;
    logic [CT_W-1:0]  r_remaining;
    logic [PER_W-1:0] r_eff_period;
    logic             r_need_setup;
    logic             r_abort_pend;
    logic             r_live;

    logic             w_accept;
    logic             w_stop;
    logic             w_steps_nz;
    logic             w_need_setup;
    logic [PER_W-1:0] w_eff;
    logic [PER_W-1:0] w_low_load;
    logic [CT_W-1:0]  w_pos_next;
    logic             w_zero;
    logic             w_timer_load;
    logic [PER_W-1:0] w_timer_val;
    logic             w_sleep;

    assign cmd_ready    = r_live & (r_state == ST_IDLE) & enable_in & ~halt;
    assign w_accept     = cmd_valid & cmd_ready;
    assign w_stop       = halt | ~enable_in;
    assign w_steps_nz   = |cmd_steps;
    assign w_need_setup = (cmd_dir != r_dir) | r_need_setup;
    // Period compare is one bit wider so 2*PULSE_W cannot overflow PER_W.
    assign w_eff        = ({1'b0, cmd_period} < TWO_PW) ? TWO_PW[PER_W-1:0] : cmd_period;
    assign w_low_load   = r_eff_period - PER_W'(PULSE_W + 1);
    assign w_pos_next   = (r_dir == DIR_FWD) ? r_position + CT_W'(1) : r_position - CT_W'(1);

    always_comb begin
        w_timer_load = 1'b0;
        w_timer_val  = HIGH_LOAD;
        case (r_state)
            ST_IDLE: begin
                w_timer_load = w_accept;
                if (w_need_setup) w_timer_val = SETUP_LOAD;
            end
            ST_SETUP: w_timer_load = w_zero;
            ST_HIGH: begin
                w_timer_load = w_zero;
                w_timer_val  = w_low_load;
            end
            ST_LOW:  w_timer_load = w_zero;
            default: w_timer_load = 1'b0;
        endcase
    end

    step_timer #(.PER_W(PER_W)) u_timer (
        .i_clk      (CLK),
        .i_rst_n    (resetn),
        .i_load     (w_timer_load),
        .i_load_val (w_timer_val),
        .o_zero     (w_zero)
    );

`ifdef STEP_SEQ_IDLE_TIMEOUT_EN
    localparam int IT_W = $clog2(IDLE_TIMEOUT + 1);

    logic [IT_W-1:0] r_idle_cnt;
    logic            r_timed_out;
    logic            w_to_hit;

    assign w_to_hit = (r_state == ST_IDLE) & r_motor_en & ~r_timed_out &
                      (r_idle_cnt == IT_W'(IDLE_TIMEOUT - 1));

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_idle_cnt  <= '0;
            r_timed_out <= 1'b0;
        end else if (w_accept || !enable_in || r_state != ST_IDLE) begin
            r_idle_cnt  <= '0;
            r_timed_out <= 1'b0;
        end else if (r_motor_en && !r_timed_out) begin
            if (w_to_hit) r_timed_out <= 1'b1;
            else          r_idle_cnt  <= r_idle_cnt + IT_W'(1);
        end
    end

    assign w_sleep = r_timed_out | w_to_hit;
`else
    assign w_sleep = 1'b0;
`endif

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_step       <= 1'b0;
            r_dir        <= DIR_REV;
            r_motor_en   <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_position   <= '0;
            r_remaining  <= '0;
            r_eff_period <= '0;
            r_need_setup <= 1'b1;
            r_abort_pend <= 1'b0;
            r_live       <= 1'b0;
        end else begin
            r_live     <= 1'b1;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
            r_motor_en <= enable_in & (w_accept | ~w_sleep);

            // A disabled driver always gets a full dir setup on its next move.
            if (w_accept && w_steps_nz) r_need_setup <= 1'b0;
            else if (!r_motor_en)       r_need_setup <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (!w_steps_nz) begin
                            r_done <= 1'b1;
                        end else begin
                            r_remaining  <= cmd_steps;
                            r_eff_period <= w_eff;
                            if (w_need_setup) begin
                                r_dir   <= cmd_dir;
                                r_state <= ST_SETUP;
                            end else begin
                                r_state    <= ST_HIGH;
                                r_step     <= 1'b1;
                                r_position <= w_pos_next;
                            end
                        end
                    end
                end
                ST_SETUP: begin
                    if (w_stop) begin
                        r_state   <= ST_IDLE;
                        r_done    <= 1'b1;
                        r_aborted <= 1'b1;
                    end else if (w_zero) begin
                        r_state    <= ST_HIGH;
                        r_step     <= 1'b1;
                        r_position <= w_pos_next;
                    end
                end
                ST_HIGH: begin
                    // An abort request during the pulse is held until the pulse completes.
                    if (w_zero) begin
                        r_step       <= 1'b0;
                        r_remaining  <= r_remaining - CT_W'(1);
                        r_abort_pend <= 1'b0;
                        if (w_stop || r_abort_pend) begin
                            r_state   <= ST_IDLE;
                            r_done    <= 1'b1;
                            r_aborted <= 1'b1;
                        end else begin
                            r_state <= ST_LOW;
                        end
                    end else if (w_stop) begin
                        r_abort_pend <= 1'b1;
                    end
                end
                ST_LOW: begin
                    if (w_stop) begin
                        r_state   <= ST_IDLE;
                        r_done    <= 1'b1;
                        r_aborted <= 1'b1;
                    end else if (w_zero) begin
                        if (r_remaining == '0) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= ST_HIGH;
                            r_step     <= 1'b1;
                            r_position <= w_pos_next;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign step     = r_step;
    assign dir      = r_dir;
    assign motor_en = r_motor_en;
    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign aborted  = r_aborted;
    assign position = r_position;

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer against a cycle-timeline model of moves.
module tb_step_sequencer;

    localparam int PW = 16;
    localparam int DS = 8;

    logic        CLK = 1'b0;
    logic        resetn;
    logic        enable_in;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_steps;
    logic        cmd_dir;
    logic [31:0] cmd_period;
    logic        halt;
    logic        step;
    logic        dir;
    logic        motor_en;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [31:0] position;

    step_sequencer dut (
        .CLK(CLK), .resetn(resetn), .enable_in(enable_in),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_steps(cmd_steps),
        .cmd_dir(cmd_dir), .cmd_period(cmd_period), .halt(halt),
        .step(step), .dir(dir), .motor_en(motor_en), .busy(busy),
        .done(done), .aborted(aborted), .position(position)
    );

    always #5 CLK = ~CLK;

    longint cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pos;
    logic        m_dir;
    bit          m_need;

    // Observations of one move
    longint acc_cyc;
    longint obs_rise[$];
    int     obs_width[$];
    longint obs_done;
    logic   obs_abt, obs_ready, obs_men, obs_busy;

    function automatic longint eff_of(input logic [31:0] p);
        return (p < 32'(2 * PW)) ? longint'(2 * PW) : longint'(p);
    endfunction

    task automatic do_reset();
        resetn = 1'b0; cmd_valid = 1'b0; halt = 1'b0; enable_in = 1'b1;
        repeat (3) @(negedge CLK);
        resetn = 1'b1;
        m_pos = '0; m_dir = 1'b0; m_need = 1'b1;
    endtask

    task automatic issue(input logic [31:0] s, input logic d, input logic [31:0] p);
        int n;
        cmd_steps = s; cmd_dir = d; cmd_period = p; cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
        if (cmd_ready !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL issue_ready: cmd_ready=%b required 1", cmd_ready);
            cmd_valid = 1'b0;
        end else begin
            acc_cyc = cyc;
            @(posedge CLK);
            #1 cmd_valid = 1'b0;
        end
    endtask

    // kind 1: raise halt k_off cycles after rise number k_rise; kind 2: drop enable at acc+k_off
    task automatic collect(input int kind, input int k_rise, input int k_off, input int budget);
        int  w;
        bit  prev;
        obs_rise.delete(); obs_width.delete();
        obs_done = -1; obs_abt = 0; obs_ready = 0; obs_men = 0; obs_busy = 0;
        prev = 0; w = 0;
        for (int n = 0; n < budget; n++) begin
            @(negedge CLK);
            if (step && !prev) begin obs_rise.push_back(cyc); w = 0; end
            if (step) w++;
            if (!step && prev) obs_width.push_back(w);
            prev = step;
            if (kind == 1 && obs_rise.size() == k_rise && cyc == obs_rise[$] + k_off) halt = 1'b1;
            if (kind == 2 && cyc == acc_cyc + k_off) enable_in = 1'b0;
            if (done) begin
                obs_done = cyc; obs_abt = aborted; obs_ready = cmd_ready;
                obs_men = motor_en; obs_busy = busy;
                break;
            end
        end
        if (obs_done < 0) begin
            n_checks++; n_fail++;
            $display("FAIL collect_timeout: no done within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; enable_in = 1'b1; halt = 1'b0; cmd_valid = 1'b0;
        cmd_steps = '0; cmd_dir = 1'b0; cmd_period = '0;
        repeat (2) @(negedge CLK);
        n_checks++; if (step !== 1'b0)     begin n_fail++; $display("FAIL rst_step: got %b want 0", step); end
        n_checks++; if (dir !== 1'b0)      begin n_fail++; $display("FAIL rst_dir: got %b want 0", dir); end
        n_checks++; if (motor_en !== 1'b0) begin n_fail++; $display("FAIL rst_motor_en: got %b want 0", motor_en); end
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
        n_checks++; if (aborted !== 1'b0)  begin n_fail++; $display("FAIL rst_aborted: got %b want 0", aborted); end
        n_checks++; if (position !== 32'd0) begin n_fail++; $display("FAIL rst_position: got %0d want 0", position); end
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
        resetn = 1'b1;
        m_pos = '0; m_dir = 1'b0; m_need = 1'b1;
        @(negedge CLK);
        n_checks++; if (motor_en !== 1'b1) begin n_fail++; $display("FAIL motor_en_follow: got %b want 1", motor_en); end
    endtask

    task automatic test_moves();
        int          t_steps[4] = '{3, 2, 1, 2};
        bit          t_dir[4]   = '{1'b1, 1'b1, 1'b0, 1'b1};
        int          t_per[4]   = '{40, 40, 40, 10};
        longint      first, eff;
        bit          setup;
        for (int k = 0; k < 4; k++) begin
            setup = (t_dir[k] != m_dir) || m_need;
            issue(32'(t_steps[k]), t_dir[k], 32'(t_per[k]));
            collect(0, 0, 0, 2000);
            eff   = eff_of(32'(t_per[k]));
            first = acc_cyc + (setup ? DS + 1 : 1);
            m_pos = t_dir[k] ? m_pos + 32'(t_steps[k]) : m_pos - 32'(t_steps[k]);
            m_dir = t_dir[k]; m_need = 0;
            n_checks++;
            if (obs_rise.size() != t_steps[k] || obs_width.size() != t_steps[k]) begin
                n_fail++; $display("FAIL move%0d_pulses: got %0d rises want %0d", k, obs_rise.size(), t_steps[k]);
            end else begin
                for (int i = 0; i < t_steps[k]; i++) begin
                    n_checks++;
                    if (obs_rise[i] != first + i * eff) begin
                        n_fail++; $display("FAIL move%0d_rise%0d: got cycle %0d want %0d", k, i, obs_rise[i], first + i * eff);
                    end
                    n_checks++;
                    if (obs_width[i] != PW) begin
                        n_fail++; $display("FAIL move%0d_width%0d: got %0d want %0d", k, i, obs_width[i], PW);
                    end
                end
            end
            n_checks++; if (obs_done != first + t_steps[k] * eff) begin n_fail++; $display("FAIL move%0d_done: got cycle %0d want %0d", k, obs_done, first + t_steps[k] * eff); end
            n_checks++; if (obs_abt !== 1'b0) begin n_fail++; $display("FAIL move%0d_aborted: got %b want 0", k, obs_abt); end
            n_checks++; if (position !== m_pos) begin n_fail++; $display("FAIL move%0d_position: got %0d want %0d", k, position, m_pos); end
            n_checks++; if (dir !== m_dir) begin n_fail++; $display("FAIL move%0d_dir: got %b want %b", k, dir, m_dir); end
        end
    endtask

    task automatic test_zero_steps();
        issue(32'd0, ~m_dir, 32'd77);
        collect(0, 0, 0, 20);
        n_checks++; if (obs_done != acc_cyc + 1) begin n_fail++; $display("FAIL zero_done: got cycle %0d want %0d", obs_done, acc_cyc + 1); end
        n_checks++; if (obs_rise.size() != 0) begin n_fail++; $display("FAIL zero_pulses: got %0d want 0", obs_rise.size()); end
        n_checks++; if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b want 0", obs_busy); end
        n_checks++; if (obs_abt !== 1'b0) begin n_fail++; $display("FAIL zero_aborted: got %b want 0", obs_abt); end
        n_checks++; if (position !== m_pos) begin n_fail++; $display("FAIL zero_position: got %0d want %0d", position, m_pos); end
    endtask

    task automatic test_halt_high();
        longint first;
        bit     setup;
        setup = (1'b1 != m_dir) || m_need;
        issue(32'd100, 1'b1, 32'd40);
        collect(1, 2, 4, 3000);
        first = acc_cyc + (setup ? DS + 1 : 1);
        m_pos = m_pos + 32'd2; m_dir = 1'b1; m_need = 0;
        n_checks++; if (obs_rise.size() != 2) begin n_fail++; $display("FAIL halt_hi_pulses: got %0d want 2", obs_rise.size()); end
        n_checks++; if (obs_width.size() != 2 || obs_width[obs_width.size()-1] != PW) begin n_fail++; $display("FAIL halt_hi_width: got %0d pulses, last width wrong, want %0d", obs_width.size(), PW); end
        n_checks++; if (obs_done != first + 40 + PW) begin n_fail++; $display("FAIL halt_hi_done: got cycle %0d want %0d", obs_done, first + 40 + PW); end
        n_checks++; if (obs_abt !== 1'b1) begin n_fail++; $display("FAIL halt_hi_aborted: got %b want 1", obs_abt); end
        n_checks++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL halt_hi_ready: got %b want 0", obs_ready); end
        n_checks++; if (position !== m_pos) begin n_fail++; $display("FAIL halt_hi_position: got %0d want %0d", position, m_pos); end
        halt = 1'b0;
        @(negedge CLK);
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL halt_release_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_halt_low();
        longint first;
        bit     setup;
        setup = (1'b0 != m_dir) || m_need;
        issue(32'd5, 1'b0, 32'd50);
        collect(1, 1, 20, 3000);
        first = acc_cyc + (setup ? DS + 1 : 1);
        m_pos = m_pos - 32'd1; m_dir = 1'b0; m_need = 0;
        n_checks++; if (obs_rise.size() != 1) begin n_fail++; $display("FAIL halt_lo_pulses: got %0d want 1", obs_rise.size()); end
        n_checks++; if (obs_done != first + 21) begin n_fail++; $display("FAIL halt_lo_done: got cycle %0d want %0d", obs_done, first + 21); end
        n_checks++; if (obs_abt !== 1'b1) begin n_fail++; $display("FAIL halt_lo_aborted: got %b want 1", obs_abt); end
        n_checks++; if (position !== m_pos) begin n_fail++; $display("FAIL halt_lo_position: got %0d want %0d", position, m_pos); end
        halt = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_enable_drop();
        issue(32'd3, ~m_dir, 32'd40);
        collect(2, 0, 3, 200);
        m_dir = ~m_dir; m_need = 1;
        n_checks++; if (obs_done != acc_cyc + 4) begin n_fail++; $display("FAIL endrop_done: got cycle %0d want %0d", obs_done, acc_cyc + 4); end
        n_checks++; if (obs_rise.size() != 0) begin n_fail++; $display("FAIL endrop_pulses: got %0d want 0", obs_rise.size()); end
        n_checks++; if (obs_abt !== 1'b1) begin n_fail++; $display("FAIL endrop_aborted: got %b want 1", obs_abt); end
        n_checks++; if (obs_men !== 1'b0) begin n_fail++; $display("FAIL endrop_motor_en: got %b want 0", obs_men); end
        n_checks++; if (position !== m_pos) begin n_fail++; $display("FAIL endrop_position: got %0d want %0d", position, m_pos); end
        enable_in = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_back_to_back_random();
        int          pick[5] = '{0, 31, 32, 33, 2};
        logic [31:0] s, p;
        logic        d;
        bit          setup;
        longint      first, eff;
        for (int k = 0; k < 24; k++) begin
            s = 32'($urandom_range(0, 4));
            d = 1'($urandom_range(0, 1));
            p = ($urandom_range(0, 3) == 0) ? 32'(pick[$urandom_range(0, 4)]) : 32'($urandom_range(1, 70));
            setup = (d != m_dir) || m_need;
            issue(s, d, p);
            collect(0, 0, 0, 2000);
            eff = eff_of(p);
            if (s == 0) begin
                first = acc_cyc;
                n_checks++; if (obs_done != acc_cyc + 1) begin n_fail++; $display("FAIL rnd%0d_zero_done: got %0d want %0d", k, obs_done, acc_cyc + 1); end
            end else begin
                first = acc_cyc + (setup ? DS + 1 : 1);
                m_pos = d ? m_pos + s : m_pos - s;
                m_dir = d; m_need = 0;
                n_checks++; if (obs_done != first + longint'(s) * eff) begin n_fail++; $display("FAIL rnd%0d_done: got %0d want %0d", k, obs_done, first + longint'(s) * eff); end
            end
            n_checks++;
            if (obs_rise.size() != int'(s)) begin
                n_fail++; $display("FAIL rnd%0d_pulses: got %0d want %0d", k, obs_rise.size(), s);
            end else begin
                for (int i = 0; i < int'(s); i++) begin
                    n_checks++;
                    if (obs_rise[i] != first + i * eff || obs_width[i] != PW) begin
                        n_fail++; $display("FAIL rnd%0d_pulse%0d: got rise %0d width %0d want rise %0d width %0d", k, i, obs_rise[i], obs_width[i], first + i * eff, PW);
                    end
                end
            end
            n_checks++; if (obs_abt !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_aborted: got %b want 0", k, obs_abt); end
            n_checks++; if (position !== m_pos) begin n_fail++; $display("FAIL rnd%0d_position: got %0d want %0d", k, position, m_pos); end
        end
    endtask

    task automatic test_reset_mid_pulse_and_wrap();
        int n;
        issue(32'd5, 1'b1, 32'd40);
        n = 0;
        while (step !== 1'b1 && n < 100) begin @(negedge CLK); n++; end
        #2 resetn = 1'b0;
        #1;
        n_checks++; if (step !== 1'b0) begin n_fail++; $display("FAIL async_reset_step: got %b want 0", step); end
        n_checks++; if (position !== 32'd0) begin n_fail++; $display("FAIL async_reset_position: got %0d want 0", position); end
        do_reset();
        issue(32'd1, 1'b0, 32'd40);
        collect(0, 0, 0, 200);
        n_checks++; if (obs_rise.size() != 1 || obs_rise[0] != acc_cyc + DS + 1) begin n_fail++; $display("FAIL wrap_rise: got %0d rises want 1 at %0d", obs_rise.size(), acc_cyc + DS + 1); end
        n_checks++; if (position !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_position: got %h want ffffffff", position); end
    endtask

    initial begin
        test_reset();
        test_moves();
        test_zero_steps();
        test_halt_high();
        test_halt_low();
        test_enable_drop();
        test_back_to_back_random();
        test_reset_mid_pulse_and_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
